elastic_delay_xbar: RTL and testbench

//  Parametrised N-channel ready/valid delay unit. It generalises the fixed 2-channel, 3-cycle swapping delay unit.

---
 rtl/elastic_delay_xbar.sv | 95 +++++++++
 tb/tb_elastic_delay_xbar.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_delay_xbar.sv
// elastic_delay_xbar: N-lane elastic ready/valid delay line with optional lane reversal,
// synchronous flush and per-lane occupancy counters.
module elastic_delay_xbar #(
  parameter  int WIDTH    = 5,
  parameter  int CHANNELS = 2,
  parameter  int LATENCY  = 3,
  parameter  int REVERSE  = 1,
  localparam int OCC_W    = $clog2(LATENCY + 1)
) (
  input  logic                      CLK,
  input  logic                      ASYNCRESETN,
  input  logic                      FLUSH,
  input  logic [WIDTH*CHANNELS-1:0] I_data,
  input  logic [CHANNELS-1:0]       I_valid,
  output logic [CHANNELS-1:0]       I_ready,
  output logic [WIDTH*CHANNELS-1:0] O_data,
  output logic [CHANNELS-1:0]       O_valid,
  input  logic [CHANNELS-1:0]       O_ready,
  output logic [OCC_W*CHANNELS-1:0] OCC
);

  // One pipeline per output lane; pipeline p is fed by input lane SRC.
  for (genvar p = 0; p < CHANNELS; p++) begin : g_pipe
    localparam int SRC = (REVERSE != 0) ? CHANNELS - 1 - p : p;

    logic [LATENCY-1:0] v_q;
    logic [WIDTH-1:0]   d_q [LATENCY];
    logic [LATENCY-1:0] adv;
    logic [LATENCY-1:0] load;
    logic [OCC_W-1:0]   occ_q;
    logic               in_valid;
    logic               in_ready;
    logic               in_fire;
    logic               out_fire;
    logic [WIDTH-1:0]   in_data;

    assign in_valid = I_valid[SRC];
    assign in_data  = I_data[SRC*WIDTH +: WIDTH];

    // A stage may advance when the output is ready or any later stage is a bubble.
    always_comb begin
      logic tail_full;
      // NOTE: defaults before the loop keep this block free of inferred latches.
      adv       = '0;
      // NOTE: blocking assignments here are intentional; tail_full is a running
      // combinational AND, not state.
      tail_full = 1'b1;
      for (int s = LATENCY - 1; s >= 0; s--) begin
        adv[s]    = O_ready[p] | ~tail_full;
        tail_full = tail_full & v_q[s];
      end
    end

    assign load     = ~v_q | adv;
    assign in_ready = load[0] & ~FLUSH;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = v_q[LATENCY-1] & O_ready[p] & ~FLUSH;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
        v_q <= '0;
        // NOTE: data registers are reset as well so O_data reads zero out of reset;
        // flush clears only the valids.
        for (int s = 0; s < LATENCY; s++) d_q[s] <= '0;
      end else if (FLUSH) begin
        v_q <= '0;
      end else begin
        if (load[0]) v_q[0] <= in_valid;
        if (load[0] && in_valid) d_q[0] <= in_data;
        for (int s = 1; s < LATENCY; s++) begin
          if (load[s]) v_q[s] <= v_q[s-1];
          if (load[s] && v_q[s-1]) d_q[s] <= d_q[s-1];
        end
      end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
        occ_q <= '0;
      end else if (FLUSH) begin
        occ_q <= '0;
      end else if (in_fire && !out_fire) begin
        occ_q <= occ_q + 1'b1;
      end else if (!in_fire && out_fire) begin
        occ_q <= occ_q - 1'b1;
      end
    end

    assign I_ready[SRC]                = in_ready;
    assign O_valid[p]                  = v_q[LATENCY-1] & ~FLUSH;
    assign O_data[p*WIDTH +: WIDTH]    = d_q[LATENCY-1];
    assign OCC[p*OCC_W +: OCC_W]       = occ_q;
  end

endmodule

// File: tb/tb_elastic_delay_xbar.sv
// Directed testbench for elastic_delay_xbar: default 2x3 reversing unit plus a 4-lane,
// 1-stage straight-through instance.
module tb_elastic_delay_xbar;

  logic CLK;
  logic ASYNCRESETN;
  logic FLUSH;

  // Instance A: defaults (WIDTH 5, CHANNELS 2, LATENCY 3, REVERSE 1, OCC_W 2)
  logic [9:0] a_idata;
  logic [1:0] a_ivalid, a_iready, a_ovalid, a_oready;
  logic [9:0] a_odata;
  logic [3:0] a_occ;

  // Instance B: WIDTH 8, CHANNELS 4, LATENCY 1, REVERSE 0, OCC_W 1
  logic [31:0] b_idata, b_odata;
  logic [3:0]  b_ivalid, b_iready, b_ovalid, b_oready, b_occ;

  int n_checks = 0;
  int n_fail   = 0;

  elastic_delay_xbar u_dut_a (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .FLUSH(FLUSH),
    .I_data(a_idata), .I_valid(a_ivalid), .I_ready(a_iready),
    .O_data(a_odata), .O_valid(a_ovalid), .O_ready(a_oready), .OCC(a_occ)
  );

  elastic_delay_xbar #(.WIDTH(8), .CHANNELS(4), .LATENCY(1), .REVERSE(0)) u_dut_b (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .FLUSH(FLUSH),
    .I_data(b_idata), .I_valid(b_ivalid), .I_ready(b_iready),
    .O_data(b_odata), .O_valid(b_ovalid), .O_ready(b_oready), .OCC(b_occ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    ASYNCRESETN = 1'b0;
    FLUSH = 1'b0;
    a_idata = '0; a_ivalid = '0; a_oready = '0;
    b_idata = '0; b_ivalid = '0; b_oready = '0;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if (a_ovalid !== 2'b00 || a_occ !== 4'h0 || a_odata !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_a ovalid=%b occ=%h odata=%h, want 00/0/000", a_ovalid, a_occ, a_odata);
    end
    n_checks++;
    if (a_iready !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_iready got %b want 11", a_iready);
    end
    n_checks++;
    if (b_ovalid !== 4'h0 || b_occ !== 4'h0 || b_odata !== 32'h0 || b_iready !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_b ovalid=%h occ=%h odata=%h iready=%h", b_ovalid, b_occ, b_odata, b_iready);
    end
    ASYNCRESETN = 1'b1;
  endtask

  task automatic test_single_beat();
    logic [1:0] exp_v;
    logic [1:0] exp_occ;
    for (int t = 0; t < 5; t++) begin
      @(negedge CLK);
      a_ivalid = (t == 0) ? 2'b01 : 2'b00;
      a_idata  = (t == 0) ? 10'h00A : 10'h000;
      a_oready = 2'b11;
      #1;
      exp_v   = (t == 3) ? 2'b10 : 2'b00;
      exp_occ = (t >= 1 && t <= 3) ? 2'd1 : 2'd0;
      n_checks++;
      if (a_ovalid !== exp_v) begin
        n_fail++;
        $display("FAIL single_ovalid t=%0d got %b want %b", t, a_ovalid, exp_v);
      end
      n_checks++;
      if (a_occ[3:2] !== exp_occ) begin
        n_fail++;
        $display("FAIL single_occ1 t=%0d got %0d want %0d", t, a_occ[3:2], exp_occ);
      end
      if (t == 3) begin
        n_checks++;
        if (a_odata[9:5] !== 5'h0A) begin
          n_fail++;
          $display("FAIL single_odata got %h want 0a", a_odata[9:5]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_v;
    logic [4:0] exp_l1, exp_l0;
    for (int t = 0; t < 12; t++) begin
      @(negedge CLK);
      a_oready = 2'b11;
      a_ivalid = (t < 8) ? 2'b11 : 2'b00;
      a_idata  = {5'(5'h10 + t), 5'(t + 1)};
      #1;
      n_checks++;
      if (a_iready !== 2'b11) begin
        n_fail++;
        $display("FAIL b2b_iready t=%0d got %b want 11", t, a_iready);
      end
      exp_v = (t >= 3 && t <= 10) ? 2'b11 : 2'b00;
      n_checks++;
      if (a_ovalid !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_ovalid t=%0d got %b want %b", t, a_ovalid, exp_v);
      end
      if (t >= 3 && t <= 10) begin
        exp_l1 = 5'(t - 2);
        exp_l0 = 5'(5'h10 + t - 3);
        n_checks++;
        if (a_odata !== {exp_l1, exp_l0}) begin
          n_fail++;
          $display("FAIL b2b_odata t=%0d got %h/%h want %h/%h",
                   t, a_odata[9:5], a_odata[4:0], exp_l1, exp_l0);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_occ [10];
    int exp_rdy [10];
    int exp_v   [10];
    int exp_d   [10];
    exp_occ = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0};
    exp_rdy = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    exp_v   = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    exp_d   = '{0, 0, 0, 'h11, 'h11, 'h11, 'h12, 'h13, 'h14, 0};
    for (int t = 0; t < 10; t++) begin
      @(negedge CLK);
      a_oready = (t < 5) ? 2'b10 : 2'b11;
      a_ivalid = (t <= 5) ? 2'b10 : 2'b00;
      a_idata  = {((t < 3) ? 5'(5'h11 + t) : 5'h14), 5'h00};
      #1;
      n_checks++;
      if (a_iready[1] !== 1'(exp_rdy[t]) || a_iready[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_iready t=%0d got %b want %0d1", t, a_iready, exp_rdy[t]);
      end
      n_checks++;
      if (a_occ[1:0] !== 2'(exp_occ[t])) begin
        n_fail++;
        $display("FAIL bp_occ0 t=%0d got %0d want %0d", t, a_occ[1:0], exp_occ[t]);
      end
      n_checks++;
      if (a_ovalid !== {1'b0, 1'(exp_v[t])}) begin
        n_fail++;
        $display("FAIL bp_ovalid t=%0d got %b want 0%0d", t, a_ovalid, exp_v[t]);
      end
      if (exp_v[t] != 0) begin
        n_checks++;
        if (a_odata[4:0] !== 5'(exp_d[t])) begin
          n_fail++;
          $display("FAIL bp_odata t=%0d got %h want %h", t, a_odata[4:0], 5'(exp_d[t]));
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int t = 0; t < 9; t++) begin
      @(negedge CLK);
      FLUSH    = (t == 3);
      a_oready = (t < 3) ? 2'b00 : 2'b11;
      a_ivalid = (t < 2) ? 2'b01 : ((t == 3) ? 2'b11 : 2'b00);
      a_idata  = (t == 3) ? 10'h3FE : {5'h00, 5'(5'h05 + t)};
      #1;
      if (t == 2) begin
        n_checks++;
        if (a_occ[3:2] !== 2'd2) begin
          n_fail++;
          $display("FAIL flush_occ_before got %0d want 2", a_occ[3:2]);
        end
      end
      if (t == 3) begin
        n_checks++;
        if (a_iready !== 2'b00) begin
          n_fail++;
          $display("FAIL flush_iready got %b want 00", a_iready);
        end
      end
      if (t == 4) begin
        n_checks++;
        if (a_occ !== 4'h0) begin
          n_fail++;
          $display("FAIL flush_occ_after got %h want 0", a_occ);
        end
      end
      if (t >= 3) begin
        n_checks++;
        if (a_ovalid !== 2'b00) begin
          n_fail++;
          $display("FAIL flush_ovalid t=%0d got %b want 00", t, a_ovalid);
        end
      end
    end
    FLUSH = 1'b0;
  endtask

  task automatic test_lane_independence();
    logic [3:0] exp_rdy, exp_v;
    logic [7:0] exp_d;
    // Phase A: one beat per lane, straight through, one cycle latency.
    for (int t = 0; t < 2; t++) begin
      @(negedge CLK);
      b_oready = 4'hF;
      b_ivalid = (t == 0) ? 4'hF : 4'h0;
      b_idata  = 32'hC3C2C1C0;
      #1;
      n_checks++;
      if (b_ovalid !== ((t == 1) ? 4'hF : 4'h0)) begin
        n_fail++;
        $display("FAIL lane_a_ovalid t=%0d got %h", t, b_ovalid);
      end
      if (t == 1) begin
        n_checks++;
        if (b_odata !== 32'hC3C2C1C0) begin
          n_fail++;
          $display("FAIL lane_a_odata got %h want c3c2c1c0", b_odata);
        end
      end
    end
    // Phase B: lane 2 stalled, others stream.
    for (int t = 0; t < 8; t++) begin
      @(negedge CLK);
      b_oready = (t < 6) ? 4'b1011 : 4'hF;
      b_ivalid = (t < 5) ? 4'hF : 4'h0;
      for (int c = 0; c < 4; c++) b_idata[c*8 +: 8] = {4'(t + 1), 4'(c)};
      #1;
      exp_rdy = (t == 0 || t >= 6) ? 4'hF : 4'b1011;
      exp_v   = (t == 0 || t == 7) ? 4'h0 : ((t == 6) ? 4'b0100 : 4'hF);
      n_checks++;
      if (b_iready !== exp_rdy) begin
        n_fail++;
        $display("FAIL lane_b_iready t=%0d got %b want %b", t, b_iready, exp_rdy);
      end
      n_checks++;
      if (b_ovalid !== exp_v) begin
        n_fail++;
        $display("FAIL lane_b_ovalid t=%0d got %b want %b", t, b_ovalid, exp_v);
      end
      n_checks++;
      if (b_occ[2] !== ((t >= 1 && t <= 6) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL lane_b_occ2 t=%0d got %b", t, b_occ[2]);
      end
      for (int c = 0; c < 4; c++) begin
        if (exp_v[c]) begin
          exp_d = (c == 2) ? 8'h12 : {4'(t), 4'(c)};
          n_checks++;
          if (b_odata[c*8 +: 8] !== exp_d) begin
            n_fail++;
            $display("FAIL lane_b_odata t=%0d lane=%0d got %h want %h", t, c, b_odata[c*8 +: 8], exp_d);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int t = 0; t < 4; t++) begin
      @(negedge CLK);
      a_oready = 2'b11;
      a_ivalid = 2'b11;
      a_idata  = {5'(5'h08 + t), 5'(5'h01 + t)};
    end
    #1;
    n_checks++;
    if (a_ovalid !== 2'b11) begin
      n_fail++;
      $display("FAIL arst_pre_ovalid got %b want 11", a_ovalid);
    end
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    n_checks++;
    if (a_ovalid !== 2'b00 || a_occ !== 4'h0 || a_odata !== 10'h0) begin
      n_fail++;
      $display("FAIL arst_immediate ovalid=%b occ=%h odata=%h want 00/0/000", a_ovalid, a_occ, a_odata);
    end
    @(negedge CLK);
    a_ivalid = 2'b00;
    #1;
    ASYNCRESETN = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge CLK);
      a_ivalid = (t == 0) ? 2'b10 : 2'b00;
      a_idata  = 10'h380;
      #1;
      n_checks++;
      if (a_ovalid !== ((t == 3) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL arst_fresh_ovalid t=%0d got %b", t, a_ovalid);
      end
      if (t == 3) begin
        n_checks++;
        if (a_odata[4:0] !== 5'h1C) begin
          n_fail++;
          $display("FAIL arst_fresh_odata got %h want 1c", a_odata[4:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_lane_independence();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
